// File: rtl/bs_rr_rbtr_9drvrs.sv
// Round-robin bus arbiter/sequencer: IDLE -> POP -> PUSH transfer of one driver word per 3 cycles.
// Optional drop counter for invalid destinations is enabled with `define BS_RBTR_DROP_CNT_EN.
module bs_rr_rbtr_9drvrs #(
  parameter int          bits      = 32,
  parameter int          drvrs     = 9,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs*bits-1:0]   D_pop,
  output logic [drvrs-1:0]        pop,
  output logic [drvrs-1:0]        push,
  output logic [bits-1:0]         D_push,
  output logic                    bus_busy,
  output logic [3:0]              grant_id,
  output logic [15:0]             drop_cnt
);

  localparam int               IW      = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [7:0]       DRVRS8  = 8'(drvrs);
  localparam logic [drvrs-1:0] ONE     = {{(drvrs-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        last_grant;
  logic [bits-1:0]   data_q;
  logic              win_found;
  logic [3:0]        win_id;
  logic [IW-1:0]     idx;
  logic [7:0]        dest;
  logic [drvrs-1:0]  mask;

  // Search starts one past the last winner and wraps, so a held request waits at most drvrs-1 transfers.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 1; k <= drvrs; k++) begin
      idx = IW'((int'(last_grant) + k) % drvrs);
      if (!win_found && pndng[idx]) begin
        win_found = 1'b1;
        win_id    = 4'(idx);
      end
    end
  end

  always_comb begin
    dest = data_q[bits-1 -: 8];
    mask = '0;
    if (dest < DRVRS8)
      mask = ONE << dest;
    else if (dest == broadcast)
      mask = ~(ONE << grant_id);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = win_found ? POP : IDLE;
      POP:     state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // D_push holds its last value after PUSH; only the strobes return to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id   <= '0;
      last_grant <= 4'(drvrs - 1);
      data_q     <= '0;
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
      bus_busy   <= 1'b0;
    end else begin
      bus_busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          push <= '0;
          if (win_found) begin
            grant_id   <= win_id;
            last_grant <= win_id;
            data_q     <= D_pop[int'(win_id)*bits +: bits];
            pop        <= ONE << win_id;
          end else begin
            pop <= '0;
          end
        end
        POP: begin
          pop    <= '0;
          push   <= mask;
          D_push <= data_q;
        end
        PUSH: begin
          pop  <= '0;
          push <= '0;
        end
        default: begin
          pop  <= '0;
          push <= '0;
        end
      endcase
    end
  end

`ifdef BS_RBTR_DROP_CNT_EN
  // Counts words whose destination matched no driver; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      drop_cnt <= '0;
    else if (state == POP && mask == '0 && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
